// File: rtl/alu_pkg.sv
// Shared op codes and state encoding for the execute-stage ALU.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_SLTU = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_MUL  = 4'd11
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Signed radix-2 shift-add multiplier on operand magnitudes.
// First step runs on the start edge so the product is ready WIDTH cycles later.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             busy_q, busy_d;
   logic             neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0]   step_hi, step_lo, step_mc, addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] mag;

   function automatic logic [WIDTH-1:0] abs_of(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   always_comb begin
      step_hi = start ? '0 : hi_q;
      step_lo = start ? abs_of(b) : lo_q;
      step_mc = start ? abs_of(a) : mcand_q;
      addend  = step_lo[0] ? step_mc : '0;
      sum     = {1'b0, step_hi} + {1'b0, addend};
      mag     = {sum[WIDTH:1], sum[0], step_lo[WIDTH-1:1]};
      product = neg_q ? -mag : mag;
      done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

      busy_d  = busy_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      if (flush) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         busy_d  = 1'b1;
         cnt_d   = CNT_W'(1);
         neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
         mcand_d = step_mc;
         hi_d    = mag[2*WIDTH-1:WIDTH];
         lo_d    = mag[WIDTH-1:0];
      end else if (busy_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         hi_d  = mag[2*WIDTH-1:WIDTH];
         lo_d  = mag[WIDTH-1:0];
         if (done) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= 1'b0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         busy_q  <= busy_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle ops plus a
// sequential signed multiplier, results held in output registers.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    operand1,
   input  logic [WIDTH-1:0]    operand2,
   input  logic [ALU_OP_W-1:0] alu_control,
   input  logic [SHAMT_W-1:0]  shift_amount,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    alu_result,
   output logic [WIDTH-1:0]    result_hi,
   output logic                zero,
   output logic                overflow,
   output logic                illegal_op
);

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;

   logic               accept, is_mul, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   sum, diff, sc_res;
   logic               sc_ovf, sc_ill;

   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready)
                      && !flush && !reset;
   assign accept    = in_valid && in_ready;
   assign is_mul    = (alu_control == OP_MUL);
   assign mul_start = accept && is_mul;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .flush   (flush),
      .a       (operand1),
      .b       (operand2),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_comb begin
      sum    = operand1 + operand2;
      diff   = operand1 - operand2;
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      unique case (alu_control)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1])
                     && (sum[WIDTH-1] != operand1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1])
                     && (diff[WIDTH-1] != operand1[WIDTH-1]);
         end
         OP_AND:  sc_res = operand1 & operand2;
         OP_OR:   sc_res = operand1 | operand2;
         OP_XOR:  sc_res = operand1 ^ operand2;
         OP_NOR:  sc_res = ~(operand1 | operand2);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                            $signed(operand1) < $signed(operand2)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
         OP_SLL:  sc_res = operand1 << shift_amount;
         OP_SRL:  sc_res = operand1 >> shift_amount;
         OP_SRA:  sc_res = $signed(operand1) >>> shift_amount;
         OP_MUL:  sc_res = '0;
         default: sc_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      hi_d        = hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      ill_d       = ill_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      // flush wins over both completion and acceptance
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else if (state_q == MUL) begin
         if (mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            res_d       = mul_prod[WIDTH-1:0];
            hi_d        = mul_prod[2*WIDTH-1:WIDTH];
            zero_d      = (mul_prod == '0);
            ovf_d       = 1'b0;
            ill_d       = 1'b0;
         end
      end else if (accept) begin
         if (is_mul) begin
            state_d = MUL;
         end else begin
            out_valid_d = 1'b1;
            res_d       = sc_res;
            hi_d        = '0;
            zero_d      = (sc_res == '0);
            ovf_d       = sc_ovf;
            ill_d       = sc_ill;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         ill_q       <= ill_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_result = res_q;
   assign result_hi  = hi_q;
   assign zero       = zero_q;
   assign overflow   = ovf_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

   localparam int W = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         z;
      logic         ov;
      logic         il;
      logic [7:0]   lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] operand1 = '0;
   logic [W-1:0] operand2 = '0;
   logic [3:0]   alu_control = '0;
   logic [4:0]   shift_amount = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] alu_result;
   logic [W-1:0] result_hi;
   logic         zero;
   logic         overflow;
   logic         illegal_op;

   int n_cmp = 0;
   int n_bad = 0;

   alu_pipe #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .operand1     (operand1),
      .operand2     (operand2),
      .alu_control  (alu_control),
      .shift_amount (shift_amount),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_result   (alu_result),
      .result_hi    (result_hi),
      .zero         (zero),
      .overflow     (overflow),
      .illegal_op   (illegal_op)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int sh);
      exp_t   e;
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e = '0;
      e.lat = 8'd1;
      case (op)
         4'd0: begin r = sa + sb; e.lo = r[W-1:0]; e.ov = (r > MAXS) || (r < MINS); end
         4'd1: begin r = sa - sb; e.lo = r[W-1:0]; e.ov = (r > MAXS) || (r < MINS); end
         4'd2: e.lo = a & b;
         4'd3: e.lo = a | b;
         4'd4: e.lo = a ^ b;
         4'd5: e.lo = ~(a | b);
         4'd6: e.lo = (sa < sb) ? 1 : 0;
         4'd7: e.lo = (a < b) ? 1 : 0;
         4'd8: e.lo = a << sh;
         4'd9: e.lo = a >> sh;
         4'd10: begin r = sa >>> sh; e.lo = r[W-1:0]; end
         4'd11: begin
            r = sa * sb;
            e.lo = r[W-1:0];
            e.hi = r[2*W-1:W];
            e.lat = 8'(W);
         end
         default: e.il = 1'b1;
      endcase
      e.z = (op == 4'd11) ? ({e.hi, e.lo} == '0) : (e.lo == '0);
      return e;
   endfunction

   task automatic accept(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh,
                         output bit ok);
      int n;
      alu_control  = op;
      operand1     = a;
      operand2     = b;
      shift_amount = sh;
      in_valid     = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      ok = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({in_ready, out_valid, alu_result, result_hi, zero, overflow, illegal_op} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h z=%b ov=%b il=%b want all 0",
                  in_ready, out_valid, alu_result, result_hi, zero, overflow, illegal_op);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   logic [3:0]   d_op [12] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd10, 4'd9, 4'd8, 4'd13,
                               4'd2, 4'd5, 4'd4, 4'd3};
   logic [W-1:0] d_a  [12] = '{32'h7fffffff, 32'd5, 32'hffffffff, 32'hffffffff,
                               32'h80000000, 32'h80000000, 32'd1, 32'd5,
                               32'hf0f0f0f0, 32'h0, 32'h12345678, 32'h00ff0000};
   logic [W-1:0] d_b  [12] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0,
                               32'd6, 32'hff00ff00, 32'h0, 32'h12345678, 32'h0000ff00};
   logic [4:0]   d_sh [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd0,
                               5'd0, 5'd0, 5'd0, 5'd0};

   task automatic test_directed;
      exp_t e;
      bit   ok;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         e = model(d_op[i], d_a[i], d_b[i], int'(d_sh[i]));
         accept(d_op[i], d_a[i], d_b[i], d_sh[i], ok);
         n_cmp++;
         if (!ok || {out_valid, result_hi, alu_result, zero, overflow, illegal_op} !==
             {1'b1, e.hi, e.lo, e.z, e.ov, e.il}) begin
            n_bad++;
            $display("FAIL directed[%0d] op=%0d: got acc=%b vld=%b hi=%h res=%h z=%b ov=%b il=%b want vld=1 hi=%h res=%h z=%b ov=%b il=%b",
                     i, d_op[i], ok, out_valid, result_hi, alu_result, zero, overflow,
                     illegal_op, e.hi, e.lo, e.z, e.ov, e.il);
         end
      end
   endtask

   task automatic test_mul;
      logic [W-1:0] ma [3] = '{32'hfffffffd, 32'h80000000, 32'h7fffffff};
      logic [W-1:0] mb [3] = '{32'd7, 32'h80000000, 32'h80000000};
      exp_t e;
      bit   ok, stall_bad;
      int   lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = model(4'd11, ma[i], mb[i], 0);
         accept(4'd11, ma[i], mb[i], 5'd0, ok);
         lat = 1;
         stall_bad = 1'b0;
         while (!out_valid && lat < 80) begin
            if (in_ready !== 1'b0) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
         end
         n_cmp++;
         if (!ok || stall_bad || lat != W ||
             {out_valid, result_hi, alu_result, zero, overflow} !== {1'b1, e.hi, e.lo, e.z, 1'b0}) begin
            n_bad++;
            $display("FAIL mul[%0d]: got acc=%b stall_bad=%b lat=%0d prod=%h_%h z=%b ov=%b want lat=%0d prod=%h_%h z=%b ov=0",
                     i, ok, stall_bad, lat, result_hi, alu_result, zero, overflow,
                     W, e.hi, e.lo, e.z);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] edges [6] = '{32'h0, 32'h1, 32'hffffffff, 32'h7fffffff,
                                  32'h80000000, 32'h80000001};
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic [4:0]   sh;
      exp_t e;
      bit   ok;
      int   lat;
      out_ready = 1'b1;
      for (int i = 0; i < 120; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         sh = 5'($urandom_range(0, 31));
         e  = model(op, a, b, int'(sh));
         accept(op, a, b, sh, ok);
         lat = 1;
         while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
         end
         n_cmp++;
         if (!ok || lat != int'(e.lat) ||
             {result_hi, alu_result, zero, overflow, illegal_op} !== {e.hi, e.lo, e.z, e.ov, e.il}) begin
            n_bad++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h sh=%0d: got acc=%b lat=%0d hi=%h res=%h z=%b ov=%b il=%b want lat=%0d hi=%h res=%h z=%b ov=%b il=%b",
                     i, op, a, b, sh, ok, lat, result_hi, alu_result, zero, overflow,
                     illegal_op, e.lat, e.hi, e.lo, e.z, e.ov, e.il);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e1, e2;
      bit   ok, bad;
      e1 = model(4'd0, 32'h7fffffff, 32'd1, 0);
      e2 = model(4'd1, 32'd3, 32'd10, 0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      accept(4'd0, 32'h7fffffff, 32'd1, 5'd0, ok);
      bad = !ok;
      for (int k = 0; k < 5; k++) begin
         if ({out_valid, in_ready, alu_result, overflow, zero} !== {1'b1, 1'b0, e1.lo, e1.ov, e1.z})
            bad = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL backpressure_hold: got vld=%b rdy=%b res=%h ov=%b want vld=1 rdy=0 res=%h ov=%b",
                  out_valid, in_ready, alu_result, overflow, e1.lo, e1.ov);
      end
      out_ready    = 1'b1;
      alu_control  = 4'd1;
      operand1     = 32'd3;
      operand2     = 32'd10;
      in_valid     = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, alu_result, overflow, zero} !== {1'b1, e2.lo, e2.ov, e2.z}) begin
         n_bad++;
         $display("FAIL b2b_result: got vld=%b res=%h want vld=1 res=%h",
                  out_valid, alu_result, e2.lo);
      end
   endtask

   task automatic test_flush;
      bit ok, seen;
      out_ready = 1'b1;
      accept(4'd11, 32'd123, 32'd456, 5'd0, ok);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      n_cmp++;
      if (!ok || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_gates_ready: got acc=%b rdy=%b want acc=1 rdy=0", ok, in_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL flush_after: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL flush_no_result: got out_valid=1 want 0");
      end
   endtask

   task automatic test_reset_mid_mul;
      bit ok1, ok2, seen;
      out_ready = 1'b1;
      accept(4'd0, 32'd5, 32'd5, 5'd0, ok1);
      accept(4'd11, 32'd3, 32'd5, 5'd0, ok2);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (!ok1 || !ok2 ||
          {in_ready, out_valid, alu_result, result_hi, zero, overflow, illegal_op} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_mul: got acc=%b%b rdy=%b vld=%b res=%h hi=%h z=%b want acc=11 all 0",
                  ok1, ok2, in_ready, out_valid, alu_result, result_hi, zero);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid || !in_ready) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL reset_mid_mul_after: got stray result or stall want idle");
      end
   endtask

   initial begin
      #2;
      test_reset;
      test_directed;
      test_mul;
      test_random;
      test_back_to_back;
      test_flush;
      test_reset_mid_mul;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
